// File: rtl/riscv_configs.sv
// Shared RISC-V core configuration: datapath width, reset vector and NOP encoding.
package riscv_configs;

   localparam int unsigned CFG_XLEN     = 32;
   localparam logic [31:0] CFG_RESET_PC = 32'h0000_0000;
   // addi x0, x0, 0
   localparam logic [31:0] CFG_NOP      = 32'h0000_0013;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with count-derived full/empty and a synchronous flush.
module riscv_sync_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_IF,
   input  logic             i_rstn,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [PTR_W:0]   o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign o_full   = (count_q == FULL_CNT);
   assign o_empty  = (count_q == '0);
   assign o_count  = count_q;
   assign o_rdata  = mem_q[rd_ptr_q];

   // Push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = i_push & (~o_full | i_pop);
   assign do_pop  = i_pop & ~o_empty;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (do_pop && !do_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_IF) begin
      if (!i_rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_IF) begin
      if (i_rstn && !i_flush && do_push) mem_q[wr_ptr_q] <= i_wdata;
   end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: PC generation feeding a prefetch queue ahead of ID.
module riscv_fetch_queue
   import riscv_configs::*;
#(
   parameter int unsigned    XLEN     = CFG_XLEN,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(CFG_RESET_PC),
   localparam int unsigned   PTR_W    = $clog2(DEPTH)
) (
   input  logic            clk_IF,
   input  logic            i_rstn,
   output logic [XLEN-1:0] o_fetch_pc,
   output logic            o_fetch_en,
   input  logic [XLEN-1:0] i_fetch_instr,
   input  logic            i_fetch_valid,
   input  logic            i_stall,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_deq_valid,
   output logic [XLEN-1:0] o_deq_instr,
   output logic [XLEN-1:0] o_deq_pc,
   output logic [XLEN-1:0] o_deq_pc4,
   input  logic            i_deq_ready,
   output logic [PTR_W:0]  o_count,
   output logic            o_full,
   output logic            o_empty
);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   pc_plus4;
   logic              push, pop;
   logic [3*XLEN-1:0] wdata, rdata;

   assign pc_plus4   = pc_q + XLEN'(4);
   assign o_fetch_pc = pc_q;

   // Redirect squashes both ends of the queue for this cycle.
   assign pop        = i_deq_ready & ~o_empty & ~i_redirect_valid;
   assign o_fetch_en = i_rstn & ~i_redirect_valid & ~i_stall & (~o_full | pop);
   assign push       = o_fetch_en & i_fetch_valid;
   assign wdata      = {pc_q, pc_plus4, i_fetch_instr};

   always_comb begin
      pc_d = pc_q;
      if (i_redirect_valid) pc_d = i_redirect_pc;
      else if (push)        pc_d = pc_plus4;
   end

   always_ff @(posedge clk_IF) begin
      if (!i_rstn) pc_q <= RESET_PC;
      else         pc_q <= pc_d;
   end

   riscv_sync_fifo #(
      .WIDTH (3*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_IF  (clk_IF),
      .i_rstn  (i_rstn),
      .i_flush (i_redirect_valid),
      .i_push  (push),
      .i_wdata (wdata),
      .i_pop   (pop),
      .o_rdata (rdata),
      .o_count (o_count),
      .o_full  (o_full),
      .o_empty (o_empty)
   );

   assign o_deq_valid = ~o_empty;
   assign o_deq_pc    = rdata[3*XLEN-1:2*XLEN];
   assign o_deq_pc4   = rdata[2*XLEN-1:XLEN];
   assign o_deq_instr = rdata[XLEN-1:0];

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue; imem returns pc ^ 0xA5A50000.
module tb_riscv_fetch_queue;

   logic        clk_IF = 1'b0;
   logic        i_rstn;
   logic [31:0] o_fetch_pc;
   logic        o_fetch_en;
   logic [31:0] i_fetch_instr;
   logic        i_fetch_valid;
   logic        i_stall;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_deq_valid;
   logic [31:0] o_deq_instr;
   logic [31:0] o_deq_pc;
   logic [31:0] o_deq_pc4;
   logic        i_deq_ready;
   logic [2:0]  o_count;
   logic        o_full;
   logic        o_empty;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_IF = ~clk_IF;

   assign i_fetch_instr = o_fetch_pc ^ 32'hA5A5_0000;

   riscv_fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk_IF           (clk_IF),
      .i_rstn           (i_rstn),
      .o_fetch_pc       (o_fetch_pc),
      .o_fetch_en       (o_fetch_en),
      .i_fetch_instr    (i_fetch_instr),
      .i_fetch_valid    (i_fetch_valid),
      .i_stall          (i_stall),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_deq_valid      (o_deq_valid),
      .o_deq_instr      (o_deq_instr),
      .o_deq_pc         (o_deq_pc),
      .o_deq_pc4        (o_deq_pc4),
      .i_deq_ready      (i_deq_ready),
      .o_count          (o_count),
      .o_full           (o_full),
      .o_empty          (o_empty)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk_IF);
      #1;
   endtask

   initial begin
      i_rstn = 1'b0; i_fetch_valid = 1'b0; i_stall = 1'b0;
      i_redirect_valid = 1'b0; i_redirect_pc = '0; i_deq_ready = 1'b0;
      step(); step();
      check("rst_fetch_pc", o_fetch_pc, 32'h0);
      check("rst_empty", 32'(o_empty), 32'd1);
      check("rst_full", 32'(o_full), 32'd0);
      check("rst_deq_valid", 32'(o_deq_valid), 32'd0);
      check("rst_count", 32'(o_count), 32'd0);
      check("rst_fetch_en", 32'(o_fetch_en), 32'd0);

      // Fill: four valid fetches, no dequeue
      i_rstn = 1'b1; i_fetch_valid = 1'b1;
      #1;
      check("fill_pc0", o_fetch_pc, 32'h0);
      check("fill_en0", 32'(o_fetch_en), 32'd1);
      step();
      check("fill_pc1", o_fetch_pc, 32'h4);
      check("fill_cnt1", 32'(o_count), 32'd1);
      check("fill_head_pc", o_deq_pc, 32'h0);
      check("fill_head_pc4", o_deq_pc4, 32'h4);
      check("fill_head_instr", o_deq_instr, 32'hA5A5_0000);
      step();
      check("fill_pc2", o_fetch_pc, 32'h8);
      step();
      check("fill_pc3", o_fetch_pc, 32'hC);
      step();
      check("fill_pc4", o_fetch_pc, 32'h10);
      check("fill_full", 32'(o_full), 32'd1);
      check("fill_cnt4", 32'(o_count), 32'd4);
      check("fill_en_off", 32'(o_fetch_en), 32'd0);
      step();
      check("full_pc_hold", o_fetch_pc, 32'h10);
      check("full_cnt_hold", 32'(o_count), 32'd4);

      // Full with simultaneous pop and push
      i_deq_ready = 1'b1;
      #1;
      check("fp_en", 32'(o_fetch_en), 32'd1);
      check("fp_head0", o_deq_pc, 32'h0);
      step();
      check("fp_head1", o_deq_pc, 32'h4);
      check("fp_cnt1", 32'(o_count), 32'd4);
      check("fp_pc1", o_fetch_pc, 32'h14);
      step();
      check("fp_head2", o_deq_pc, 32'h8);
      check("fp_cnt2", 32'(o_count), 32'd4);
      check("fp_pc2", o_fetch_pc, 32'h18);

      // Drain to two entries without fetching (queue: 8,C,10,14)
      i_fetch_valid = 1'b0;
      step(); step();
      check("drain_cnt", 32'(o_count), 32'd2);
      check("drain_head", o_deq_pc, 32'h10);
      check("drain_pc_hold", o_fetch_pc, 32'h18);

      // Redirect beats pop and fetch
      i_redirect_valid = 1'b1; i_redirect_pc = 32'h100; i_fetch_valid = 1'b1;
      #1;
      check("rd_en_off", 32'(o_fetch_en), 32'd0);
      step();
      i_redirect_valid = 1'b0; i_deq_ready = 1'b0; i_fetch_valid = 1'b0;
      #1;
      check("rd_empty", 32'(o_empty), 32'd1);
      check("rd_cnt", 32'(o_count), 32'd0);
      check("rd_pc", o_fetch_pc, 32'h100);
      check("rd_deq_valid", 32'(o_deq_valid), 32'd0);

      // fetch_valid pattern 1,0,0,1
      i_fetch_valid = 1'b1; step();
      check("tog_pc1", o_fetch_pc, 32'h104);
      i_fetch_valid = 1'b0; step();
      check("tog_pc2", o_fetch_pc, 32'h104);
      step();
      check("tog_pc3", o_fetch_pc, 32'h104);
      check("tog_cnt3", 32'(o_count), 32'd1);
      i_fetch_valid = 1'b1; step();
      check("tog_pc4", o_fetch_pc, 32'h108);
      check("tog_cnt4", 32'(o_count), 32'd2);
      check("tog_head_instr", o_deq_instr, 32'hA5A5_0100);

      // Stall with dequeue: drains while fetch is held off
      i_stall = 1'b1; i_deq_ready = 1'b1;
      #1;
      check("st_en0", 32'(o_fetch_en), 32'd0);
      step();
      check("st_cnt1", 32'(o_count), 32'd1);
      check("st_head_instr", o_deq_instr, 32'hA5A5_0104);
      check("st_en1", 32'(o_fetch_en), 32'd0);
      step();
      check("st_empty", 32'(o_empty), 32'd1);
      check("st_en2", 32'(o_fetch_en), 32'd0);
      step();
      check("st_cnt3", 32'(o_count), 32'd0);
      check("st_pc3", o_fetch_pc, 32'h108);
      check("st_en3", 32'(o_fetch_en), 32'd0);

      // PC wrap at top of address space
      i_stall = 1'b0; i_deq_ready = 1'b0; i_fetch_valid = 1'b0;
      i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
      step();
      i_redirect_valid = 1'b0; i_fetch_valid = 1'b1;
      #1;
      check("wr_pc0", o_fetch_pc, 32'hFFFF_FFFC);
      step();
      check("wr_pc1", o_fetch_pc, 32'h0);
      check("wr_head_pc", o_deq_pc, 32'hFFFF_FFFC);
      check("wr_head_pc4", o_deq_pc4, 32'h0);
      check("wr_head_instr", o_deq_instr, 32'h5A5A_FFFC);
      step();
      check("wr_pc2", o_fetch_pc, 32'h4);
      check("wr_cnt2", 32'(o_count), 32'd2);

      // Reset mid-stream
      i_rstn = 1'b0;
      #1;
      check("mr_en_off", 32'(o_fetch_en), 32'd0);
      step();
      check("mr_pc", o_fetch_pc, 32'h0);
      check("mr_cnt", 32'(o_count), 32'd0);
      check("mr_empty", 32'(o_empty), 32'd1);
      check("mr_full", 32'(o_full), 32'd0);
      check("mr_deq_valid", 32'(o_deq_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
